// File: rtl/layer3_output_scheduler_pkg.sv
// Shared constants and state encoding for the layer-3 output scheduler.
//   DefNOut / DefDw / DefAw : default neuron count, Q8.8 data width, weight-memory address width
//   Frac                    : Q8.8 fraction width (documentation of the number format)
//   state_e                 : scheduler FSM states, 3-bit encoding
package layer3_output_scheduler_pkg;

  localparam int unsigned DefNOut = 9;
  localparam int unsigned DefDw   = 16;
  localparam int unsigned DefAw   = 4;
  localparam int unsigned Frac    = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StLoad    = 3'd2,
    StCapture = 3'd3,
    StDone    = 3'd4
  } state_e;

endpackage

// File: rtl/layer3_output_scheduler.sv
// Time-shares one layer-3 MAC and one sigmoid across N_OUT output neurons.
// Per neuron: read weights/bias from the weight memory, register the MAC operands, then capture
// the sigmoid result (act_in) into that neuron's output slot. All slots are presented together.
//
// Optional build macro: WMEM_PREFETCH_EN -- overlap the weight read of neuron n+1 with the
// capture of neuron n (2 cycles per neuron instead of 3). Slot contents are identical.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     accept a21/a22 latent activations
//   a21, a22              latent activations (Q8.8)
//   wmem_rd, wmem_addr    weight-memory read strobe and neuron index
//   wmem_w1/w2/b          weight memory data, valid one cycle after wmem_rd
//   mac_d1..mac_b         registered operands of the shared MAC
//   act_in                sigmoid(MAC) result, combinational from mac_*
//   out_valid/out_ready   result handshake
//   out_bus               slot n at bits [DW*n +: DW]
//   busy                  high whenever not idle
module layer3_output_scheduler
  import layer3_output_scheduler_pkg::*;
#(
  parameter int unsigned N_OUT = DefNOut,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned AW    = DefAw
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       a21,
  input  logic [DW-1:0]       a22,
  output logic                wmem_rd,
  output logic [AW-1:0]       wmem_addr,
  input  logic [DW-1:0]       wmem_w1,
  input  logic [DW-1:0]       wmem_w2,
  input  logic [DW-1:0]       wmem_b,
  output logic [DW-1:0]       mac_d1,
  output logic [DW-1:0]       mac_d2,
  output logic [DW-1:0]       mac_w1,
  output logic [DW-1:0]       mac_w2,
  output logic [DW-1:0]       mac_b,
  input  logic [DW-1:0]       act_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_OUT*DW-1:0] out_bus,
  output logic                busy
);

  localparam logic [AW-1:0] LastIdx = AW'(N_OUT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] addr_q;
  logic          rd;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] a21_q, a22_q;

  // Next-state, index and read-strobe decode
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    rd      = 1'b0;
    rd_addr = addr_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StFetch;
          n_d     = '0;
        end
      end
      StFetch: begin
        rd      = 1'b1;
        rd_addr = n_q;
        state_d = StLoad;
      end
      StLoad: begin
        state_d = StCapture;
      end
      StCapture: begin
        if (n_q == LastIdx) begin
          state_d = StDone;
        end else begin
          n_d = n_q + 1'b1;
`ifdef WMEM_PREFETCH_EN
          // Read the next neuron's weights now so LOAD can follow directly.
          rd      = 1'b1;
          rd_addr = n_q + 1'b1;
          state_d = StLoad;
`else
          state_d = StFetch;
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      if (rd) begin
        addr_q <= rd_addr;
      end
    end
  end

  // Activation latches, loaded only on the input handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a21_q <= '0;
      a22_q <= '0;
    end else if (state_q == StIdle && in_valid) begin
      a21_q <= a21;
      a22_q <= a22;
    end
  end

  // Shared MAC operand registers; held outside LOAD so act_in stays stable in CAPTURE/DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_d1 <= '0;
      mac_d2 <= '0;
      mac_w1 <= '0;
      mac_w2 <= '0;
      mac_b  <= '0;
    end else if (state_q == StLoad) begin
      mac_d1 <= a21_q;
      mac_d2 <= a22_q;
      mac_w1 <= wmem_w1;
      mac_w2 <= wmem_w2;
      mac_b  <= wmem_b;
    end
  end

  // Output slot bank, one register per neuron
  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    localparam logic [AW-1:0] SlotIdx = AW'(i);
    logic [DW-1:0] slot_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_q <= '0;
      end else if (state_q == StCapture && n_q == SlotIdx) begin
        slot_q <= act_in;
      end
    end

    assign out_bus[DW*i +: DW] = slot_q;
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign wmem_rd   = rd;
  // Address holds its last issued value between reads
  assign wmem_addr = rd_addr;

endmodule

// File: tb/tb_layer3_output_scheduler.sv
// Scoreboard bench for layer3_output_scheduler: weight memory model, act_in looped from mac_b,
// expected slot vectors and read addresses queued at stimulus time, popped by monitors.
module tb_layer3_output_scheduler;

  localparam int N  = 9;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BW = N * DW;

`ifdef WMEM_PREFETCH_EN
  localparam int Lat  = 20;
  localparam int Cap3 = 9;
  localparam int Cap4 = 11;
`else
  localparam int Lat  = 28;
  localparam int Cap3 = 12;
  localparam int Cap4 = 15;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] a21, a22;
  logic          wmem_rd;
  logic [AW-1:0] wmem_addr;
  logic [DW-1:0] wmem_w1, wmem_w2, wmem_b;
  logic [DW-1:0] mac_d1, mac_d2, mac_w1, mac_w2, mac_b;
  logic [DW-1:0] act_in;
  logic          out_valid, out_ready;
  logic [BW-1:0] out_bus;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0] exp_bus_q [$];
  logic [AW-1:0] exp_addr_q [$];

  always #5 clk = ~clk;

  layer3_output_scheduler #(.N_OUT(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a21       (a21),
    .a22       (a22),
    .wmem_rd   (wmem_rd),
    .wmem_addr (wmem_addr),
    .wmem_w1   (wmem_w1),
    .wmem_w2   (wmem_w2),
    .wmem_b    (wmem_b),
    .mac_d1    (mac_d1),
    .mac_d2    (mac_d2),
    .mac_w1    (mac_w1),
    .mac_w2    (mac_w2),
    .mac_b     (mac_b),
    .act_in    (act_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus),
    .busy      (busy)
  );

  // Weight memory model: one-cycle read latency
  always @(posedge clk) begin
    if (wmem_rd) begin
      wmem_w1 <= 16'h0100 + 16'(wmem_addr);
      wmem_w2 <= 16'h0200 + 16'(wmem_addr);
      wmem_b  <= 16'h0010 * (16'(wmem_addr) + 16'd1);
    end
  end

  assign act_in = mac_b;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_bus();
    logic [BW-1:0] v;
    for (int i = 0; i < N; i++) v[DW*i +: DW] = 16'h0010 * 16'(i + 1);
    return v;
  endfunction

  task automatic push_addrs();
    for (int i = 0; i < N; i++) exp_addr_q.push_back(AW'(i));
  endtask

  // Result monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_bus_q.size() == 0) begin
        chk("unexpected_result", out_bus, '0);
        if (out_bus == '0) begin
          n_fail++;
          $display("FAIL unexpected_result: got result, want none");
        end
      end else begin
        chk("out_bus", out_bus, exp_bus_q.pop_front());
      end
    end
  end

  // Address monitor
  always @(negedge clk) begin
    if (!rst && wmem_rd) begin
      if (exp_addr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rd: got addr %0d, want no read", wmem_addr);
      end else begin
        chk("wmem_addr", BW'(wmem_addr), BW'(exp_addr_q.pop_front()));
      end
    end
  end

  // One full pass; caller is just past a posedge with the DUT idle
  task automatic run_pass(input int bp, input bit poke);
    int  cyc;
    bit  seen;
    @(negedge clk);
    chk("in_ready_idle", BW'(in_ready), BW'(1));
    a21       = 16'h0180;
    a22       = 16'hFF00;
    in_valid  = 1'b1;
    out_ready = (bp == 0);
    exp_bus_q.push_back(exp_bus());
    push_addrs();
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= Lat + 5) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        chk("latency", BW'(cyc), BW'(Lat));
      end else begin
        if (cyc == 5) chk("in_ready_busy", BW'({in_ready, busy}), BW'(2'b01));
        if (cyc == Cap4) begin
          chk("mac_d1_n4", BW'(mac_d1), BW'(16'h0180));
          chk("mac_d2_n4", BW'(mac_d2), BW'(16'hFF00));
          chk("mac_w1_n4", BW'(mac_w1), BW'(16'h0104));
          chk("mac_w2_n4", BW'(mac_w2), BW'(16'h0204));
        end
        if (poke && cyc == 5) begin
          in_valid = 1'b1;
          a21      = 16'h7FFF;
        end
        if (poke && cyc == 6) in_valid = 1'b0;
        cyc++;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_valid_timeout: got none after %0d cycles, want %0d", cyc, Lat);
    end
    if (bp > 0) begin
      for (int k = 0; k < bp; k++) begin
        chk("bp_out_valid", BW'(out_valid), BW'(1));
        chk("bp_out_bus", out_bus, exp_bus());
        chk("bp_in_ready", BW'(in_ready), BW'(0));
        @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
    end
    chk("in_ready_done", BW'(in_ready), BW'(0));
    @(negedge clk);
    chk("in_ready_after", BW'({in_ready, out_valid}), BW'(2'b10));
    out_ready = 1'b0;
    a21       = 16'h0180;
    @(posedge clk);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    a21      = 16'h0180;
    a22      = 16'hFF00;
    in_valid = 1'b1;
    push_addrs();
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (Cap3) @(negedge clk);
    chk("partial_slot2", BW'(out_bus[2*DW +: DW]), BW'(16'h0030));
    #2 rst = 1'b1;
    #1;
    chk("rst_out_bus", out_bus, '0);
    chk("rst_flags", BW'({busy, in_ready, wmem_rd, out_valid}), BW'(4'b0100));
    exp_addr_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic back_to_back();
    int cnt;
    @(negedge clk);
    a21       = 16'h0180;
    a22       = 16'hFF00;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int p = 0; p < 2; p++) begin
      exp_bus_q.push_back(exp_bus());
      push_addrs();
    end
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      while (!out_valid && cnt < Lat + 10) begin
        @(negedge clk);
        cnt++;
      end
      if (!out_valid) begin
        n_tests++;
        n_fail++;
        $display("FAIL b2b_timeout: got no out_valid, want one within %0d cycles", Lat + 10);
      end
      chk("b2b_in_ready_done", BW'(in_ready), BW'(0));
      @(negedge clk);
      chk("b2b_in_ready_next", BW'(in_ready), BW'(1));
      if (p == 0) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a21       = '0;
    a22       = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_outputs", BW'({out_valid, busy, wmem_rd, wmem_addr}), '0);
    chk("rst_out_bus0", out_bus, '0);
    chk("rst_mac", BW'({mac_d1, mac_d2, mac_w1, mac_w2, mac_b}), '0);
    @(posedge clk);

    run_pass(0, 1'b0);
    run_pass(10, 1'b1);
    reset_mid();
    back_to_back();

    chk("addr_queue_left", BW'(exp_addr_q.size()), '0);
    chk("result_queue_left", BW'(exp_bus_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
